// File: rtl/tone_decoder.sv
// Speaker square-wave note recogniser: measures edge-to-edge half-periods,
// matches them against the tone-divider table and locks after a stable run.
module tone_decoder #(
  parameter int unsigned TOL     = 8,
  parameter int unsigned STABLE  = 4,
  parameter int unsigned TIMEOUT = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spk_in,
  output logic [3:0]  inx,
  output logic        locked,
  output logic        note_chg,
  output logic [10:0] meas
);

  localparam int unsigned HW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {
    SILENT,
    ACQUIRE,
    LOCKED
  } state_t;

  // Nominal half-period of note k, derived from the divider preset code.
  function automatic logic [10:0] hp_of(input int unsigned k);
    logic [10:0] code;
    case (k)
      1:       code = 11'h305;
      2:       code = 11'h390;
      3:       code = 11'h40C;
      4:       code = 11'h45C;
      5:       code = 11'h4AD;
      6:       code = 11'h50A;
      7:       code = 11'h55C;
      8:       code = 11'h58C;
      9:       code = 11'h5C8;
      10:      code = 11'h606;
      11:      code = 11'h630;
      12:      code = 11'h656;
      13:      code = 11'h684;
      14:      code = 11'h69A;
      15:      code = 11'h6C0;
      default: code = 11'h7FF;
    endcase
    return 11'(12'h800 - {1'b0, code});
  endfunction

  logic          r_sync1, r_sync2, r_sync3;
  logic          w_edge;
  logic [10:0]   r_cnt;
  logic          r_armed;
  logic          w_timeout;

  logic          w_match;
  logic [3:0]    w_match_k;
  logic [11:0]   w_h;
  logic [11:0]   w_hp;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [HW-1:0] r_hits, w_hits_nxt, w_hits_inc;
  logic [3:0]    r_inx, w_inx_nxt;
  logic          r_locked, w_locked_nxt;
  logic          r_chg, w_chg_nxt;
  logic [10:0]   r_meas, w_meas_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= spk_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge = r_sync2 ^ r_sync3;

  // Counter restarts at 1 so its value on the next edge equals the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= 11'd1;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 11'd1;
    end
  end

  // Disarming after a timeout also keeps a saturated counter from re-firing.
  assign w_timeout = r_armed && !w_edge && (r_cnt == 11'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (w_edge) begin
      r_armed <= 1'b1;
    end else if (w_timeout) begin
      r_armed <= 1'b0;
    end
  end

  assign w_h = {1'b0, r_cnt};

  always_comb begin
    w_match   = 1'b0;
    w_match_k = '0;
    w_hp      = '0;
    for (int unsigned k = 1; k <= 15; k++) begin
      w_hp = {1'b0, hp_of(k)};
      if ((w_h + 12'(TOL) >= w_hp) && (w_h <= w_hp + 12'(TOL))) begin
        w_match   = 1'b1;
        w_match_k = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SILENT;
      r_cand   <= '0;
      r_hits   <= '0;
      r_inx    <= '0;
      r_locked <= 1'b0;
      r_chg    <= 1'b0;
      r_meas   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_hits   <= w_hits_nxt;
      r_inx    <= w_inx_nxt;
      r_locked <= w_locked_nxt;
      r_chg    <= w_chg_nxt;
      r_meas   <= w_meas_nxt;
    end
  end

  assign w_hits_inc = r_hits + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_hits_nxt   = r_hits;
    w_inx_nxt    = r_inx;
    w_locked_nxt = r_locked;
    w_chg_nxt    = 1'b0;
    w_meas_nxt   = r_meas;
    if (w_edge && r_armed) begin
      w_meas_nxt = r_cnt;
      case (r_state)
        SILENT: begin
          if (w_match) begin
            w_state_nxt = ACQUIRE;
            w_cand_nxt  = w_match_k;
            w_hits_nxt  = HW'(1);
          end
        end
        ACQUIRE: begin
          if (!w_match) begin
            w_state_nxt = SILENT;
            w_hits_nxt  = '0;
          end else if (w_match_k == r_cand) begin
            w_hits_nxt = w_hits_inc;
            if (w_hits_inc >= HW'(STABLE)) begin
              w_state_nxt  = LOCKED;
              w_locked_nxt = 1'b1;
              w_inx_nxt    = r_cand;
              w_chg_nxt    = (r_cand != r_inx);
            end
          end else begin
            w_cand_nxt = w_match_k;
            w_hits_nxt = HW'(1);
          end
        end
        LOCKED: begin
          if (!w_match) begin
            w_state_nxt  = SILENT;
            w_locked_nxt = 1'b0;
            w_hits_nxt   = '0;
          end else if (w_match_k != r_inx) begin
            w_state_nxt  = ACQUIRE;
            w_cand_nxt   = w_match_k;
            w_hits_nxt   = HW'(1);
            w_locked_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = SILENT;
          w_hits_nxt  = '0;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt  = SILENT;
      w_hits_nxt   = '0;
      w_locked_nxt = 1'b0;
      w_inx_nxt    = '0;
      w_chg_nxt    = (r_inx != '0);
    end
  end

  assign inx      = r_inx;
  assign locked   = r_locked;
  assign note_chg = r_chg;
  assign meas     = r_meas;

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder: expected output changes are queued with
// the stimulus and a monitor compares each observed change in order.
module tb_tone_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spk_in = 1'b0;
  logic [3:0]  inx;
  logic        locked;
  logic        note_chg;
  logic [10:0] meas;

  typedef struct packed {
    logic [3:0]  inx;
    logic        locked;
    logic        chg;
    logic [10:0] meas;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;

  tone_decoder #(.TOL(8), .STABLE(4), .TIMEOUT(2047)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spk_in   (spk_in),
    .inx      (inx),
    .locked   (locked),
    .note_chg (note_chg),
    .meas     (meas)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int l, input int c, input int m);
    resp_t r;
    r.inx    = 4'(i);
    r.locked = 1'(l);
    r.chg    = 1'(c);
    r.meas   = 11'(m);
    exp_q.push_back(r);
  endtask

  task automatic tone(input int unsigned hp, input int unsigned n);
    repeat (n) begin
      repeat (hp) @(negedge clk);
      spk_in = ~spk_in;
    end
  endtask

  // Monitor: any change of inx/locked/meas, or a note_chg pulse, is one response.
  initial begin
    resp_t prev, cur, e;
    prev = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = {inx, locked, note_chg, meas};
      if (cur.inx != prev.inx || cur.locked != prev.locked ||
          cur.meas != prev.meas || cur.chg) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: got inx=%0d locked=%0d chg=%0d meas=%0d, expected none (t=%0t)",
                   cur.inx, cur.locked, cur.chg, cur.meas, $time);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL resp: got inx=%0d locked=%0d chg=%0d meas=%0d, expected inx=%0d locked=%0d chg=%0d meas=%0d (t=%0t)",
                     cur.inx, cur.locked, cur.chg, cur.meas, e.inx, e.locked, e.chg, e.meas, $time);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_inx", 32'(inx), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_note_chg", 32'(note_chg), 0);
    check("rst_meas", 32'(meas), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Clean 851 tone: arm + 4 intervals locks index 5
    push(0, 0, 0, 851);
    push(5, 1, 1, 851);
    tone(851, 7);

    // Switch to 320: lock drops on first interval, index 15 after four
    push(5, 0, 320, 0);
    exp_q[exp_q.size()-1].meas = 11'd320;
    exp_q[exp_q.size()-1].chg  = 1'b0;
    push(15, 1, 1, 320);
    tone(320, 4);

    // Alternating 851/758 never locks; inx stays 15
    push(15, 0, 0, 851);
    push(15, 0, 0, 758);
    push(15, 0, 0, 851);
    push(15, 0, 0, 758);
    tone(851, 1); tone(758, 1); tone(851, 1); tone(758, 1);

    // Tolerance edge: 859 locks to 5, 860 falls to SILENT
    push(15, 0, 0, 859);
    push(5, 1, 1, 859);
    push(5, 0, 0, 860);
    tone(859, 4);
    tone(860, 4);

    // Lock on index 1 then silence until timeout
    push(5, 0, 0, 1275);
    push(1, 1, 1, 1275);
    push(0, 0, 1, 1275);
    tone(1275, 4);
    repeat (2049) @(negedge clk);
    check("pre_timeout_locked", 32'(locked), 1);
    @(negedge clk);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_inx", 32'(inx), 0);
    check("timeout_note_chg", 32'(note_chg), 1);

    // First edge after timeout only re-arms
    repeat (100) @(negedge clk);
    spk_in = ~spk_in;
    push(0, 0, 0, 851);
    tone(851, 3);

    // Reset mid-acquire (hits=3)
    push(0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_outputs", 32'({inx, locked, note_chg, meas}), 0);
    spk_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 0, 851);
    push(5, 1, 1, 851);
    tone(851, 4);
    repeat (5) @(negedge clk);
    check("relock_after4_locked", 32'(locked), 0);
    repeat (846) @(negedge clk);
    spk_in = ~spk_in;
    repeat (5) @(negedge clk);
    check("relock_after5_locked", 32'(locked), 1);
    check("relock_after5_inx", 32'(inx), 5);

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
